// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: FIFO-fed command sequencer for the LCD controller cmd/cmd_valid port.
// Optional busy/done timeout enabled by defining LCD_SEQ_TMO_EN.
module lcd_cmd_seq #(
   parameter int DEPTH = 8,
   parameter int TMO   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [3:0] push_cmd,
   output logic       full,
   output logic       empty,
   output logic       ovf,
   output logic [3:0] cmd,
   output logic       cmd_valid,
   input  logic       busy,
   input  logic       done,
   output logic [7:0] issued,
   output logic       seq_done,
   output logic       err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {WAIT_RDY, ISSUE, WAIT_ACK, WAIT_DONE, FINISH} state_t;

   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TMO < 1) begin : g_bad_param
      $error("lcd_cmd_seq: bad DEPTH or TMO");
   end

   state_t st, nxt;
   logic [3:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [3:0] head;
   logic pop, push_ok, tmo_hit;

   assign head    = mem[rd_ptr];
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign pop     = st == ISSUE;
   assign push_ok = push && !seq_done && (!full || pop);

   // FIFO storage; the head is read combinationally while in ISSUE
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_cmd;
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_ok) - CW'(pop);
         if (push && full && !pop) ovf <= 1'b1;
      end
   end

`ifdef LCD_SEQ_TMO_EN
   localparam int TW = $clog2(16 * TMO) + 1;
   logic [TW-1:0] tmo_cnt;
   logic err_q;
   assign err = err_q;

   // wait counter runs only while parked in WAIT_ACK or WAIT_DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         tmo_cnt <= (st == nxt && (st == WAIT_ACK || st == WAIT_DONE)) ? tmo_cnt + TW'(1) : '0;
         if (tmo_hit) err_q <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

   // next-state logic
   always_comb begin
      nxt     = st;
      tmo_hit = 1'b0;
      case (st)
         WAIT_RDY:  nxt = (!empty && !busy) ? ISSUE : WAIT_RDY;
         ISSUE:     nxt = (head == 4'd0) ? WAIT_DONE : WAIT_ACK;
         WAIT_ACK:  nxt = busy ? WAIT_RDY : WAIT_ACK;
         WAIT_DONE: nxt = done ? FINISH : WAIT_DONE;
         default:   nxt = FINISH;
      endcase
`ifdef LCD_SEQ_TMO_EN
      if (st == WAIT_ACK && !busy && tmo_cnt == TW'(TMO - 1)) begin
         nxt     = WAIT_RDY;
         tmo_hit = 1'b1;
      end
      if (st == WAIT_DONE && !done && tmo_cnt == TW'(16 * TMO - 1)) begin
         nxt     = FINISH;
         tmo_hit = 1'b1;
      end
`endif
   end

   // state register with registered cmd/cmd_valid so cmd is zero whenever not issuing
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st        <= WAIT_RDY;
         cmd       <= 4'd0;
         cmd_valid <= 1'b0;
         issued    <= 8'd0;
         seq_done  <= 1'b0;
      end else begin
         st        <= nxt;
         cmd_valid <= nxt == ISSUE;
         cmd       <= (nxt == ISSUE) ? head : 4'd0;
         if (st == ISSUE && issued != 8'hFF) issued <= issued + 8'd1;
         if (st == WAIT_DONE && done) seq_done <= 1'b1;
      end
   end
endmodule
